// File: rtl/prog_clock_div.sv
// Multi-channel programmable clock divider: NUM_CH independent 50%-duty square
// waves with rising-edge tick strobes, glitch-free half-period reload and a shared sync restart.
module prog_clock_div #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 25000000,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] wr_val_s;

    // A programmed half-period of zero would never terminate, so it is clamped to one.
    always_comb begin
        wr_val_s = (cfg_half == ZERO_C) ? ONE_C : cfg_half;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] count_r;
        logic [CNT_W-1:0] half_act_r;
        logic [CNT_W-1:0] half_shd_r;
        logic             slow_r;
        logic             tick_r;
        logic             term_s;
        logic             wr_hit_s;

        // Terminal detect and shadow-write decode for this channel.
        always_comb begin
            term_s   = (count_r == (half_act_r - ONE_C));
            wr_hit_s = cfg_we && (cfg_sel == SEL_W'(i));
        end

        // Shadow half-period; only reaches the counter at a toggle or a sync.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                half_shd_r <= DEF_HALF_C;
            end else if (wr_hit_s) begin
                half_shd_r <= wr_val_s;
            end else begin
                half_shd_r <= half_shd_r;
            end
        end

        // Divider core: sync overrides enable; a disabled channel freezes its phase.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_r    <= ZERO_C;
                half_act_r <= DEF_HALF_C;
                slow_r     <= 1'b0;
                tick_r     <= 1'b0;
            end else if (sync) begin
                count_r    <= ZERO_C;
                half_act_r <= half_shd_r;
                slow_r     <= 1'b0;
                tick_r     <= 1'b0;
            end else if (en[i]) begin
                if (term_s) begin
                    count_r    <= ZERO_C;
                    half_act_r <= half_shd_r;
                    slow_r     <= ~slow_r;
                    tick_r     <= ~slow_r;
                end else begin
                    count_r    <= count_r + ONE_C;
                    half_act_r <= half_act_r;
                    slow_r     <= slow_r;
                    tick_r     <= 1'b0;
                end
            end else begin
                count_r    <= count_r;
                half_act_r <= half_act_r;
                slow_r     <= slow_r;
                tick_r     <= 1'b0;
            end
        end

        assign slow_clk[i] = slow_r;
        assign tick[i]     = tick_r;
    end

endmodule

// File: tb/tb_prog_clock_div.sv
// Bench for prog_clock_div: countdown-based reference model compared every cycle,
// plus hand-computed literal checks of edge timing for each scenario.
module tb_prog_clock_div;

    localparam int NC  = 3;
    localparam int CW  = 8;
    localparam int DEF = 4;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] en;
    logic          sync;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [CW-1:0] cfg_half;
    logic [NC-1:0] slow_clk;
    logic [NC-1:0] tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: cycles remaining until the next toggle, shadow value, level, tick.
    int unsigned m_rem [NC];
    int unsigned m_shd [NC];
    bit          m_lvl [NC];
    bit          m_tick[NC];

    prog_clock_div #(.NUM_CH(NC), .CNT_W(CW), .DEFAULT_HALF(DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_half (cfg_half),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one update per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                m_rem[i]  <= 32'(DEF);
                m_shd[i]  <= 32'(DEF);
                m_lvl[i]  <= 1'b0;
                m_tick[i] <= 1'b0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < NC; i++) begin
                if (cfg_we && (int'(cfg_sel) == i))
                    m_shd[i] <= (cfg_half == 8'd0) ? 32'd1 : 32'(cfg_half);
                if (sync) begin
                    m_rem[i]  <= m_shd[i];
                    m_lvl[i]  <= 1'b0;
                    m_tick[i] <= 1'b0;
                end else if (en[i]) begin
                    if (m_rem[i] == 32'd1) begin
                        m_lvl[i]  <= !m_lvl[i];
                        m_tick[i] <= !m_lvl[i];
                        m_rem[i]  <= m_shd[i];
                    end else begin
                        m_rem[i]  <= m_rem[i] - 32'd1;
                        m_tick[i] <= 1'b0;
                    end
                end else begin
                    m_tick[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n cycles, comparing DUT against the model on each falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("model slow_clk[%0d] cyc%0d", i, cyc), 32'(slow_clk[i]), 32'(m_lvl[i]));
                chk($sformatf("model tick[%0d] cyc%0d", i, cyc), 32'(tick[i]), 32'(m_tick[i]));
            end
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [CW-1:0] val);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_half = val;
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic sync_pulse();
        sync = 1'b1;
        step(1);
        sync = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 3'b111;
        sync     = 1'b0;
        cfg_we   = 1'b0;
        cfg_sel  = 2'd0;
        cfg_half = 8'd0;

        // Reset and default half-period of 4
        step(3);
        chk("reset slow_clk", 32'(slow_clk), 32'h0);
        chk("reset tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        step(3);
        chk("def pre-rise", 32'(slow_clk[0]), 32'h0);
        step(1);
        chk("def first rise", 32'(slow_clk[0]), 32'h1);
        chk("def first tick", 32'(tick[0]), 32'h1);
        step(1);
        chk("def tick one cycle", 32'(tick[0]), 32'h0);
        step(7);
        chk("def second rise", 32'(slow_clk[0]), 32'h1);
        chk("def second tick", 32'(tick[0]), 32'h1);

        // ch0 half=3, ch1 half=1, phase-aligned by sync
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd1);
        sync_pulse();
        chk("sync clears slow_clk", 32'(slow_clk), 32'h0);
        chk("sync clears tick", 32'(tick), 32'h0);
        step(1);
        chk("ch1 first rise", 32'(slow_clk[1:0]), 32'h2);
        chk("ch1 first tick", 32'(tick[1]), 32'h1);
        step(2);
        chk("ch0/ch1 coincide", 32'(slow_clk[1:0]), 32'h3);
        chk("ch0/ch1 tick", 32'(tick[1:0]), 32'h3);
        step(6);
        chk("ch0 period 6", 32'(slow_clk[0]), 32'h1);

        // Rewrite at count=1: finish the half-period of 5, then halves of 2
        wr(2'd0, 8'd5);
        sync_pulse();
        step(1);
        wr(2'd0, 8'd2);
        step(2);
        chk("rewrite hold 5", 32'(slow_clk[0]), 32'h0);
        step(1);
        chk("rewrite rise at 5", 32'(slow_clk[0]), 32'h1);
        step(2);
        chk("rewrite fall at 7", 32'(slow_clk[0]), 32'h0);
        step(2);
        chk("rewrite rise at 9", 32'(slow_clk[0]), 32'h1);

        // Rewrite on the terminal cycle: one more half of 5, then 2
        wr(2'd0, 8'd5);
        sync_pulse();
        step(4);
        wr(2'd0, 8'd2);
        chk("term-wr rise at 5", 32'(slow_clk[0]), 32'h1);
        step(4);
        chk("term-wr hold at 9", 32'(slow_clk[0]), 32'h1);
        step(1);
        chk("term-wr fall at 10", 32'(slow_clk[0]), 32'h0);
        step(2);
        chk("term-wr rise at 12", 32'(slow_clk[0]), 32'h1);

        // Freeze ch1 mid-count for 7 cycles
        wr(2'd1, 8'd3);
        wr(2'd0, 8'd2);
        sync_pulse();
        step(3);
        chk("frz ch1 rise", 32'(slow_clk[1]), 32'h1);
        step(1);
        en = 3'b101;
        step(7);
        chk("frz ch1 held", 32'(slow_clk[1]), 32'h1);
        chk("frz ch1 no tick", 32'(tick[1]), 32'h0);
        en = 3'b111;
        step(1);
        chk("frz resume count", 32'(slow_clk[1]), 32'h1);
        step(1);
        chk("frz resume fall", 32'(slow_clk[1]), 32'h0);

        // cfg_half=0 acts as 1; out-of-range select is ignored
        wr(2'd0, 8'd0);
        sync_pulse();
        step(1);
        chk("half0 rise", 32'(slow_clk[0]), 32'h1);
        step(1);
        chk("half0 fall", 32'(slow_clk[0]), 32'h0);
        wr(2'd3, 8'd1);
        sync_pulse();
        step(2);
        chk("bad sel no change", 32'(slow_clk), 32'h0);
        step(1);
        chk("bad sel ch1 rise at 3", 32'(slow_clk[1]), 32'h1);

        // Asynchronous reset while ch0 is high
        begin : wait_high
            for (int k = 0; k < 20; k++) begin
                if (m_lvl[0]) disable wait_high;
                step(1);
            end
        end
        chk("wait ch0 high", 32'(m_lvl[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset slow_clk", 32'(slow_clk), 32'h0);
        chk("async reset tick", 32'(tick), 32'h0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("post-reset pre-rise", 32'(slow_clk[0]), 32'h0);
        step(1);
        chk("post-reset default rise", 32'(slow_clk[0]), 32'h1);
        chk("post-reset tick", 32'(tick[0]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_clock_div.md
# prog_clock_div

Multi-channel programmable clock divider. Generates NUM_CH independent divided square waves from one system clock, each with a one-cycle tick strobe on its rising edge. Half-period is runtime-programmable per channel and updates glitch-free at the channel's next toggle. Drives game timers, LED blink rates and sequence pacing in the Simon-Say top level.

## Interface

Parameters:
- NUM_CH, 2, number of independent divider channels (1..16)
- CNT_W, 32, width of counters and half-period values
- DEFAULT_HALF, 25000000, half-period in clk cycles loaded into every channel at reset (must be ≥1 and < 2^CNT_W)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable; low freezes that channel
- sync  in  1  synchronous restart of all channels, phase-aligned
- cfg_we  in  1  config write strobe, one cycle
- cfg_sel  in  $clog2(NUM_CH) (min 1)  target channel of write
- cfg_half  in  CNT_W  new half-period in clk cycles
- slow_clk  out  NUM_CH  divided clock per channel, registered
- tick  out  NUM_CH  one-cycle pulse per channel, registered

## Operation

- Per-channel state: count (CNT_W), half_act (active half-period), half_shd (shadow), slow_clk bit, tick bit.
- Reset (rst_n low, async): count=0, half_act=half_shd=DEFAULT_HALF, slow_clk=0, tick=0 for all channels.
- Config: cfg_we high with cfg_sel < NUM_CH writes half_shd[cfg_sel] <= cfg_half; cfg_half==0 is stored as 1. cfg_sel ≥ NUM_CH: write ignored. Writes never touch count, half_act or slow_clk directly.
- Run (en[i]=1, sync=0):
  - count != half_act-1: count <= count+1.
  - count == half_act-1 (terminal): count <= 0, slow_clk <= ~slow_clk, half_act <= half_shd.
  - tick[i] <= 1 only in the cycle where slow_clk[i] transitions 0->1; otherwise 0.
- Freeze (en[i]=0, sync=0): count, slow_clk, half_act hold; tick=0. Shadow writes still accepted.
- Sync (highest priority after reset, overrides en): every channel count <= 0, slow_clk <= 0, tick <= 0, half_act <= half_shd.
- Simultaneous cfg write and terminal on same channel: half_act takes the old half_shd; new value takes effect at the following terminal.
- Simultaneous cfg write and sync: half_act takes the old half_shd; new value lands in half_shd.
- Channels fully independent except for sync.

## Timing

- Output period of channel i = 2*half_act cycles, 50% duty; half_act=1 gives clk/2.
- First rising edge of slow_clk after reset release or sync: after half_act cycles of enabled running (count 0..half_act-1, toggle on the next edge).
- tick rises in the same clk edge as slow_clk 0->1, lasts exactly one cycle.
- Reconfiguration latency: between 1 and half_act_old cycles until the next toggle, then new value applies for the subsequent half-period. No runt half-periods.
- Reset asserted mid-period: outputs go to reset values immediately (async); counting resumes on first posedge with rst_n high.
- count never exceeds half_act-1; no wrap past terminal.

## Test plan

- Reset: hold rst_n low, toggle clk -> slow_clk=0, tick=0 all channels; release with DEFAULT_HALF=4, en=all 1 -> slow_clk[0] rises after 4 cycles, period 8, tick pulses every 8 cycles aligned with the rising edge.
- Program ch0 half=3, ch1 half=1, then sync -> ch0 period 6, ch1 toggles every cycle (period 2), both rising edges coincide 3 cycles... ch1 every 2, ch0 every 6, first edges at cycles 3 and 1 after sync.
- Mid-period rewrite: ch0 half=5 running, write half=2 at count=1 -> current half-period completes at 5 cycles, then half-periods of 2; write landing exactly on terminal cycle -> one more half-period of 5, then 2.
- Freeze: drop en[1] for 7 cycles mid-count -> slow_clk[1] and phase hold, tick[1]=0; ch0 unaffected; resuming continues from held count.
- Edge configs: write cfg_half=0 -> behaves as half=1; write cfg_sel=NUM_CH -> no channel changes.
- Reset mid-operation: assert rst_n low between clk edges while slow_clk=1 -> slow_clk drops to 0 without waiting for clk, half reverts to DEFAULT_HALF.
